// File: rtl/idecode_q.sv
`default_nettype none
// ============================================================================
//  Module   : idecode_q
//  Brief    : Instruction queue + decode/issue stage with register-file
//             reservation check. Optional fetch bypass via IDQ_BYPASS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module idecode_q #(
   parameter int WORD  = 32,
   parameter int ADDR  = 32,
   parameter int W_OPC = 6,
   parameter int W_RD  = 5,
   parameter int DEPTH = 4,
   parameter logic [(2**W_OPC)-1:0] WB_MASK = '1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     v_i,
   input  logic [WORD-1:0]          inst_i,
   input  logic [ADDR-1:0]          addr_i,
   output logic                     stall_o,
   input  logic                     flush_i,
   input  logic                     stall_i,
   output logic                     v_o,
   output logic [WORD-1:0]          src_o,
   output logic [WORD-1:0]          dest_o,
   output logic [W_OPC-1:0]         opc_o,
   output logic                     wb_o,
   output logic [W_RD-1:0]          wb_rd_name_o,
   output logic [ADDR-1:0]          addr_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [W_RD-1:0]          rf_rd_name_o,
   output logic [W_RD-1:0]          rf_rs_name_o,
   input  logic [WORD-1:0]          rf_rd_data_i,
   input  logic [WORD-1:0]          rf_rs_data_i,
   input  logic                     rf_rd_rsv_i,
   input  logic                     rf_rs_rsv_i,
   output logic                     rf_reserve_o
);
   localparam int c_W_IMM = WORD - W_OPC - 1 - 2*W_RD;
   localparam int c_PTR   = $clog2(DEPTH);
   localparam logic [c_PTR:0]   c_FULL    = (c_PTR+1)'(DEPTH);
   localparam logic [c_PTR:0]   c_CNT_ONE = (c_PTR+1)'(1);
   localparam logic [c_PTR-1:0] c_PTR_ONE = c_PTR'(1);

   logic [WORD-1:0]  r_inst [DEPTH];
   logic [ADDR-1:0]  r_addr [DEPTH];
   logic [c_PTR-1:0] r_wr_ptr, r_rd_ptr;
   logic [c_PTR:0]   r_count;

   logic             r_v;
   logic [WORD-1:0]  r_src, r_dest;
   logic [W_OPC-1:0] r_opc;
   logic             r_wb;
   logic [W_RD-1:0]  r_wb_rd;
   logic [ADDR-1:0]  r_addr_out;

   logic             w_empty, w_full, w_bypass;
   logic             w_cand_v, w_hazard, w_issue, w_push, w_pop;
   logic [WORD-1:0]  w_cand_inst;
   logic [ADDR-1:0]  w_cand_addr;
   logic [W_OPC-1:0] w_opc;
   logic             w_immf;
   logic [W_RD-1:0]  w_rd, w_rs;
   logic [c_W_IMM-1:0] w_imm;
   logic [WORD-1:0]  w_imm_sx;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_FULL);

`ifdef IDQ_BYPASS_EN
   // An empty queue lets the fetched word act as the candidate directly.
   assign w_bypass = w_empty;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_cand_v    = w_bypass ? v_i    : ~w_empty;
   assign w_cand_inst = w_bypass ? inst_i : r_inst[r_rd_ptr];
   assign w_cand_addr = w_bypass ? addr_i : r_addr[r_rd_ptr];

   assign w_opc    = w_cand_inst[WORD-1 -: W_OPC];
   assign w_immf   = w_cand_inst[WORD-1-W_OPC];
   assign w_rd     = w_cand_inst[WORD-2-W_OPC -: W_RD];
   assign w_rs     = w_cand_inst[WORD-2-W_OPC-W_RD -: W_RD];
   assign w_imm    = w_cand_inst[c_W_IMM-1:0];
   assign w_imm_sx = {{(WORD-c_W_IMM){w_imm[c_W_IMM-1]}}, w_imm};

   assign w_hazard = rf_rd_rsv_i | (~w_immf & rf_rs_rsv_i);
   assign w_issue  = w_cand_v & ~w_hazard & ~stall_i & ~flush_i;
   assign w_pop    = w_issue & ~w_bypass;
   // A bypassed word that issues is consumed without touching the queue.
   assign w_push   = v_i & ~w_full & ~flush_i & ~(w_bypass & w_issue);

   assign stall_o      = v_i & w_full;
   assign rf_rd_name_o = w_rd;
   assign rf_rs_name_o = w_rs;
   assign rf_reserve_o = w_issue & WB_MASK[w_opc];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_inst[r_wr_ptr] <= inst_i;
         r_addr[r_wr_ptr] <= addr_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v        <= 1'b0;
         r_src      <= '0;
         r_dest     <= '0;
         r_opc      <= '0;
         r_wb       <= 1'b0;
         r_wb_rd    <= '0;
         r_addr_out <= '0;
      end else if (flush_i) begin
         r_v <= 1'b0;
      end else if (!stall_i) begin
         r_v        <= w_issue;
         r_src      <= w_immf ? w_imm_sx : rf_rs_data_i;
         r_dest     <= rf_rd_data_i;
         r_opc      <= w_opc;
         r_wb       <= WB_MASK[w_opc];
         r_wb_rd    <= w_rd;
         r_addr_out <= w_cand_addr;
      end
   end

   assign v_o          = r_v;
   assign src_o        = r_src;
   assign dest_o       = r_dest;
   assign opc_o        = r_opc;
   assign wb_o         = r_wb;
   assign wb_rd_name_o = r_wb_rd;
   assign addr_o       = r_addr_out;
   assign count_o      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_idecode_q.sv
`default_nettype none
// ============================================================================
//  Module   : tb_idecode_q
//  Brief    : Vector table plus scoreboard bench for idecode_q; latency
//             expectations follow IDQ_BYPASS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_idecode_q;
   localparam logic [63:0] c_MASK = 64'hFFFF_FFFF_FFFF_FFDF;
`ifdef IDQ_BYPASS_EN
   localparam int c_EXP_LAT = 1;
`else
   localparam int c_EXP_LAT = 2;
`endif

   logic clk = 1'b0;
   logic rst, v_i, flush_i, stall_i, stall_o, v_o, wb_o, rf_reserve_o;
   logic rf_rd_rsv_i, rf_rs_rsv_i;
   logic [31:0] inst_i, addr_i, src_o, dest_o, addr_o, rf_rd_data_i, rf_rs_data_i;
   logic [5:0]  opc_o;
   logic [4:0]  wb_rd_name_o, rf_rd_name_o, rf_rs_name_o;
   logic [2:0]  count_o;

   always #5 clk = ~clk;

   idecode_q #(.WORD(32), .ADDR(32), .W_OPC(6), .W_RD(5), .DEPTH(4), .WB_MASK(c_MASK)) dut (
      .clk(clk), .rst(rst), .v_i(v_i), .inst_i(inst_i), .addr_i(addr_i),
      .stall_o(stall_o), .flush_i(flush_i), .stall_i(stall_i), .v_o(v_o),
      .src_o(src_o), .dest_o(dest_o), .opc_o(opc_o), .wb_o(wb_o),
      .wb_rd_name_o(wb_rd_name_o), .addr_o(addr_o), .count_o(count_o),
      .rf_rd_name_o(rf_rd_name_o), .rf_rs_name_o(rf_rs_name_o),
      .rf_rd_data_i(rf_rd_data_i), .rf_rs_data_i(rf_rs_data_i),
      .rf_rd_rsv_i(rf_rd_rsv_i), .rf_rs_rsv_i(rf_rs_rsv_i),
      .rf_reserve_o(rf_reserve_o)
   );

   // Register file stand-in: data is a recognisable function of the name.
   assign rf_rd_data_i = 32'hDD00_0000 | {27'd0, rf_rd_name_o};
   assign rf_rs_data_i = 32'h5500_0000 | {27'd0, rf_rs_name_o};

   typedef struct packed {
      logic [31:0] src; logic [31:0] dest; logic [5:0] opc;
      logic wb; logic [4:0] rd; logic [31:0] addr;
   } exp_t;

   typedef struct {
      logic [5:0] opc; logic immf; logic [4:0] rd; logic [4:0] rs;
      logic [14:0] imm; logic [31:0] addr;
      logic [31:0] src; logic [31:0] dest; logic wb;
   } vec_t;

   exp_t exp_q[$];
   vec_t vt[6];
   int   n_vec = 0, n_err = 0, act_rsv = 0, exp_rsv = 0;
   logic stall_q = 1'b0;

   function automatic logic [31:0] mk(logic [5:0] opc, logic immf, logic [4:0] rd,
                                      logic [4:0] rs, logic [14:0] imm);
      return {opc, immf, rd, rs, imm};
   endfunction

   function automatic exp_t model(logic [5:0] opc, logic immf, logic [4:0] rd,
                                  logic [4:0] rs, logic [14:0] imm, logic [31:0] addr);
      exp_t e;
      e.src  = immf ? {{17{imm[14]}}, imm} : (32'h5500_0000 | {27'd0, rs});
      e.dest = 32'hDD00_0000 | {27'd0, rd};
      e.opc  = opc;
      e.wb   = c_MASK[opc];
      e.rd   = rd;
      e.addr = addr;
      return e;
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic wait_drain(string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain: %0d outputs outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_vo(string name);
      int k = 0;
      while (!v_o && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk({name, "_vo_seen"}, {127'd0, v_o}, 128'd1);
   endtask

   always @(posedge clk) stall_q <= stall_i;

   // Scoreboard: a fresh result is present when v_o is set after an unstalled edge.
   always @(negedge clk) begin
      exp_t got, e;
      if (rf_reserve_o) act_rsv++;
      if (rst && v_o && !stall_q) begin
         n_vec++;
         got = '{src: src_o, dest: dest_o, opc: opc_o, wb: wb_o, rd: wb_rd_name_o, addr: addr_o};
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: got addr=%h opc=%0d, required no output", addr_o, opc_o);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_err++;
               $display("FAIL output: got src=%h dest=%h opc=%0d wb=%b rd=%0d addr=%h, required src=%h dest=%h opc=%0d wb=%b rd=%0d addr=%h",
                        got.src, got.dest, got.opc, got.wb, got.rd, got.addr,
                        e.src, e.dest, e.opc, e.wb, e.rd, e.addr);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      vec_t a;
      vt[0] = '{opc:6'd1,  immf:1'b1, rd:5'd3,  rs:5'd0,  imm:15'h7FFB, addr:32'h0000_0100,
                src:32'hFFFF_FFFB, dest:32'hDD00_0003, wb:1'b1};
      vt[1] = '{opc:6'd2,  immf:1'b0, rd:5'd7,  rs:5'd9,  imm:15'h0000, addr:32'h0000_0104,
                src:32'h5500_0009, dest:32'hDD00_0007, wb:1'b1};
      vt[2] = '{opc:6'd5,  immf:1'b1, rd:5'd31, rs:5'd1,  imm:15'h3FFF, addr:32'h0000_0108,
                src:32'h0000_3FFF, dest:32'hDD00_001F, wb:1'b0};
      vt[3] = '{opc:6'd63, immf:1'b1, rd:5'd0,  rs:5'd31, imm:15'h4000, addr:32'hFFFF_FFFC,
                src:32'hFFFF_C000, dest:32'hDD00_0000, wb:1'b1};
      vt[4] = '{opc:6'd0,  immf:1'b0, rd:5'd16, rs:5'd31, imm:15'h1234, addr:32'h0000_0000,
                src:32'h5500_001F, dest:32'hDD00_0010, wb:1'b1};
      vt[5] = '{opc:6'd5,  immf:1'b0, rd:5'd1,  rs:5'd2,  imm:15'h7FFF, addr:32'h0000_0200,
                src:32'h5500_0002, dest:32'hDD00_0001, wb:1'b0};

      rst = 1'b0; v_i = 1'b0; inst_i = '0; addr_i = '0; flush_i = 1'b0; stall_i = 1'b0;
      rf_rd_rsv_i = 1'b0; rf_rs_rsv_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {v_o, src_o, dest_o, opc_o, wb_o, wb_rd_name_o, addr_o, count_o, stall_o}, 128'd0);
      @(posedge clk); #1 rst = 1'b1;

      // Single instructions: result, latency and reservation per vector.
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         v_i = 1'b1;
         inst_i = mk(vt[i].opc, vt[i].immf, vt[i].rd, vt[i].rs, vt[i].imm);
         addr_i = vt[i].addr;
         exp_q.push_back('{src: vt[i].src, dest: vt[i].dest, opc: vt[i].opc, wb: vt[i].wb,
                           rd: vt[i].rd, addr: vt[i].addr});
         if (vt[i].wb) exp_rsv++;
         @(posedge clk); #1 v_i = 1'b0;
         lat = 1;
         @(negedge clk);
         while (!v_o && lat < 10) begin
            @(negedge clk);
            lat++;
         end
         chk($sformatf("latency_v%0d", i), 128'(lat), 128'(c_EXP_LAT));
         wait_drain("vector");
         @(negedge clk);
         chk($sformatf("reserve_count_v%0d", i), 128'(act_rsv), 128'(exp_rsv));
      end

      // Reserved rs on the head: queue fills, fetch stalls, then in-order drain.
      rf_rs_rsv_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         v_i = 1'b1;
         inst_i = mk(6'd2, 1'b0, 5'(i + 1), 5'(i + 10), 15'd0);
         addr_i = 32'h300 + 32'(4 * i);
         exp_q.push_back(model(6'd2, 1'b0, 5'(i + 1), 5'(i + 10), 15'd0, addr_i));
         exp_rsv++;
      end
      @(posedge clk); #1;
      inst_i = mk(6'd2, 1'b0, 5'd5, 5'd14, 15'd0);
      addr_i = 32'h310;
      @(negedge clk);
      chk("hazard_full", {count_o, stall_o, v_o, rf_reserve_o}, {3'd4, 1'b1, 1'b0, 1'b0});
      @(posedge clk); #1;
      @(negedge clk);
      chk("hazard_hold", {count_o, stall_o, v_o}, {3'd4, 1'b1, 1'b0});
      @(posedge clk); #1 rf_rs_rsv_i = 1'b0;
      @(negedge clk);
      chk("full_pop_refuses_push", {stall_o, rf_reserve_o}, {1'b1, 1'b1});
      @(posedge clk); #1;
      @(negedge clk);
      chk("after_pop_count", {count_o, stall_o}, {3'd3, 1'b0});
      exp_q.push_back(model(6'd2, 1'b0, 5'd5, 5'd14, 15'd0, 32'h310));
      exp_rsv++;
      @(posedge clk); #1 v_i = 1'b0;
      @(negedge clk);
      chk("push_pop_count", 128'(count_o), 128'd3);
      wait_drain("hazard");
      @(negedge clk);
      chk("hazard_reserve_count", 128'(act_rsv), 128'(exp_rsv));

      // Execute stall with a valid output: everything holds for 5 cycles.
      a = vt[0];
      @(posedge clk); #1;
      v_i = 1'b1; inst_i = mk(a.opc, a.immf, a.rd, a.rs, a.imm); addr_i = a.addr;
      exp_q.push_back('{src: a.src, dest: a.dest, opc: a.opc, wb: a.wb, rd: a.rd, addr: a.addr});
      exp_rsv++;
      @(posedge clk); #1 v_i = 1'b0;
      wait_vo("stall");
      stall_i = 1'b1;
      v_i = 1'b1; inst_i = mk(vt[1].opc, vt[1].immf, vt[1].rd, vt[1].rs, vt[1].imm); addr_i = vt[1].addr;
      exp_q.push_back('{src: vt[1].src, dest: vt[1].dest, opc: vt[1].opc, wb: vt[1].wb,
                        rd: vt[1].rd, addr: vt[1].addr});
      exp_rsv++;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("stall_hold_c%0d", k),
             {v_o, src_o, dest_o, opc_o, wb_o, wb_rd_name_o, addr_o, rf_reserve_o},
             {1'b1, a.src, a.dest, a.opc, a.wb, a.rd, a.addr, 1'b0});
         if (k == 4) chk("stall_queue_count", 128'(count_o), 128'd1);
         @(posedge clk); #1;
         if (k == 0) v_i = 1'b0;
      end
      stall_i = 1'b0;
      wait_drain("stall");
      @(negedge clk);
      chk("stall_reserve_count", 128'(act_rsv), 128'(exp_rsv));

      // Flush with a full queue and a held valid output.
      a = vt[2];
      @(posedge clk); #1;
      v_i = 1'b1; inst_i = mk(a.opc, a.immf, a.rd, a.rs, a.imm); addr_i = a.addr;
      exp_q.push_back('{src: a.src, dest: a.dest, opc: a.opc, wb: a.wb, rd: a.rd, addr: a.addr});
      @(posedge clk); #1 v_i = 1'b0;
      wait_vo("flush");
      stall_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         v_i = 1'b1; inst_i = mk(6'd3, 1'b1, 5'(i + 20), 5'd0, 15'(i)); addr_i = 32'h400 + 32'(4 * i);
         @(posedge clk); #1;
      end
      flush_i = 1'b1; stall_i = 1'b0;
      inst_i = mk(6'd3, 1'b1, 5'd25, 5'd0, 15'd9); addr_i = 32'h410;
      exp_q.delete();
      @(negedge clk);
      chk("flush_cycle", {count_o, v_o, rf_reserve_o}, {3'd4, 1'b1, 1'b0});
      @(posedge clk); #1;
      flush_i = 1'b0; v_i = 1'b0;
      @(negedge clk);
      chk("after_flush", {count_o, v_o}, {3'd0, 1'b0});
      repeat (3) @(negedge clk);
      chk("after_flush_quiet", {count_o, v_o}, {3'd0, 1'b0});
      chk("flush_reserve_count", 128'(act_rsv), 128'(exp_rsv));

      // Asynchronous reset with three entries queued behind a reserved rd.
      rf_rd_rsv_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         v_i = 1'b1; inst_i = mk(6'd4, 1'b1, 5'(i + 2), 5'd0, 15'h1111); addr_i = 32'h500 + 32'(4 * i);
      end
      @(posedge clk); #1 v_i = 1'b0;
      @(negedge clk);
      chk("pre_reset_count", 128'(count_o), 128'd3);
      @(posedge clk); #1 rst = 1'b0;
      #1;
      chk("mid_reset", {v_o, src_o, dest_o, opc_o, wb_o, wb_rd_name_o, addr_o, count_o}, 128'd0);
      @(posedge clk); #1;
      rst = 1'b1; rf_rd_rsv_i = 1'b0;
      repeat (4) @(negedge clk);
      chk("post_reset_empty", {count_o, v_o}, {3'd0, 1'b0});
      chk("final_reserve_count", 128'(act_rsv), 128'(exp_rsv));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
